// File: rtl/minimac3_pkg.sv
// Shared constants and FSM encoding for the minimac3 PHY-side engines.
package minimac3_pkg;

  localparam logic [3:0]  PREAMBLE_NIB    = 4'h5;
  localparam logic [3:0]  SFD_NIB         = 4'hD;
  localparam int          PREAMBLE_CYCLES = 16;
  localparam logic [31:0] CRC_POLY        = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT        = 32'hFFFFFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA,
    ST_FCS,
    ST_IFG
  } tx_state_t;

endpackage

// File: rtl/minimac3_tx_if.sv
// Start/done handshake, TX buffer read port and MII transmit pins of the TX engine.
interface minimac3_tx_if;

  logic        tx_start;
  logic [10:0] tx_count;
  logic        tx_done;
  logic [10:0] txb_adr;
  logic [7:0]  txb_dat;
  logic        phy_tx_en;
  logic [3:0]  phy_tx_data;

  // The transmit engine.
  modport master (
    input  tx_start, tx_count, txb_dat,
    output tx_done, txb_adr, phy_tx_en, phy_tx_data
  );

  // Synchroniser, TX buffer and PHY side.
  modport slave (
    output tx_start, tx_count, txb_dat,
    input  tx_done, txb_adr, phy_tx_en, phy_tx_data
  );

endinterface

// File: rtl/minimac3_crc32.sv
// Combinational CRC-32 step over one nibble (reflected, LSB first).
module minimac3_crc32
  import minimac3_pkg::*;
(
  input  logic [31:0] i_crc,
  input  logic [3:0]  i_nibble,
  output logic [31:0] o_crc
);

  // Shift the four nibble bits through the reflected polynomial, bit 0 first.
  always_comb begin
    // NOTE: the output gets a value before the loop touches it, so every path assigns it and no latch is inferred.
    o_crc = i_crc;
    for (int i = 0; i < 4; i++) begin
      if (o_crc[0] ^ i_nibble[i]) o_crc = (o_crc >> 1) ^ CRC_POLY;
      else                        o_crc = o_crc >> 1;
    end
  end

endmodule

// File: rtl/minimac3_tx.sv
// PHY-side transmit engine: preamble, SFD, payload, optional FCS, then IFG and done.
module minimac3_tx
  import minimac3_pkg::*;
#(
  parameter bit          HW_FCS     = 1'b1,
  parameter int unsigned IFG_CYCLES = 24
)(
  input  logic          phy_tx_clk,
  input  logic          phy_tx_rst,
  minimac3_tx_if.master bus
);

  // All r_ registers describe what is on the MII pins in the current cycle;
  // the w_ values are what the pins and bookkeeping become after the next edge.
  tx_state_t   r_state,   w_state;
  logic [11:0] r_cnt,     w_cnt;      // nibble / cycle index within the state
  logic [10:0] r_count,   w_count;    // latched payload byte count
  logic [10:0] r_adr,     w_adr;
  logic [3:0]  r_hi_nib,  w_hi_nib;   // high half of the byte being sent; low half goes straight out
  logic [31:0] r_crc,     w_crc;
  logic        r_tx_en,   w_tx_en;
  logic [3:0]  r_tx_data, w_tx_data;
  logic        r_done,    w_done;

  logic [10:0] w_last_adr;
  logic        w_last_nib;
  logic [3:0]  w_nib;
  logic [31:0] w_crc_step;

  assign w_last_adr = r_count - 11'd1;
  assign w_last_nib = (r_cnt == {w_last_adr, 1'b1});
  // Odd index (or the SFD cycle) means the next slot starts a new byte, taken from RAM.
  assign w_nib      = r_cnt[0] ? bus.txb_dat[3:0] : r_hi_nib;

  minimac3_crc32 u_crc (
    .i_crc    (r_crc),
    .i_nibble (w_nib),
    .o_crc    (w_crc_step)
  );

  // Next-state and next-output decode for the frame sequencer.
  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_count   = r_count;
    w_adr     = r_adr;
    w_hi_nib  = r_hi_nib;
    w_crc     = r_crc;
    w_tx_en   = 1'b0;
    w_tx_data = 4'h0;
    w_done    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.tx_start) begin
          if (bus.tx_count != 11'd0) begin
            w_state   = ST_PREAMBLE;
            w_cnt     = '0;
            w_count   = bus.tx_count;
            w_adr     = '0;
            w_crc     = CRC_INIT;
            w_tx_en   = 1'b1;
            w_tx_data = PREAMBLE_NIB;
          end else begin
            w_done = 1'b1;
          end
        end
      end
      ST_PREAMBLE: begin
        w_tx_en = 1'b1;
        if (r_cnt == 12'(PREAMBLE_CYCLES - 1)) begin
          w_state   = ST_DATA;
          w_cnt     = '0;
          w_tx_data = w_nib;
          w_hi_nib  = bus.txb_dat[7:4];
          if (HW_FCS) w_crc = w_crc_step;
          if (r_adr != w_last_adr) w_adr = r_adr + 11'd1;
        end else begin
          w_cnt     = r_cnt + 12'd1;
          w_tx_data = (r_cnt == 12'(PREAMBLE_CYCLES - 2)) ? SFD_NIB : PREAMBLE_NIB;
        end
      end
      ST_DATA: begin
        if (w_last_nib) begin
          w_cnt = '0;
          if (HW_FCS) begin
            w_state   = ST_FCS;
            w_tx_en   = 1'b1;
            w_tx_data = ~r_crc[3:0];
          end else begin
            w_state = ST_IFG;
          end
        end else begin
          w_cnt     = r_cnt + 12'd1;
          w_tx_en   = 1'b1;
          w_tx_data = w_nib;
          if (HW_FCS) w_crc = w_crc_step;
          if (r_cnt[0]) begin
            w_hi_nib = bus.txb_dat[7:4];
            if (r_adr != w_last_adr) w_adr = r_adr + 11'd1;
          end
        end
      end
      ST_FCS: begin
        if (r_cnt == 12'd7) begin
          w_state = ST_IFG;
          w_cnt   = '0;
        end else begin
          w_cnt     = r_cnt + 12'd1;
          w_tx_en   = 1'b1;
          w_tx_data = ~r_crc[{r_cnt[2:0] + 3'd1, 2'b00} +: 4];
        end
      end
      ST_IFG: begin
        if (r_cnt == 12'(IFG_CYCLES - 1)) begin
          w_state = ST_IDLE;
          w_cnt   = '0;
          w_done  = 1'b1;
        end else begin
          w_cnt = r_cnt + 12'd1;
        end
      end
      default: w_state = ST_IDLE;
    endcase
  end

  // State and output registers; reset drops TX_EN immediately and abandons the frame.
  always_ff @(posedge phy_tx_clk or posedge phy_tx_rst) begin
    if (phy_tx_rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_count   <= '0;
      r_adr     <= '0;
      r_hi_nib  <= '0;
      r_crc     <= CRC_INIT;
      r_tx_en   <= 1'b0;
      r_tx_data <= 4'h0;
      r_done    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_count   <= w_count;
      r_adr     <= w_adr;
      r_hi_nib  <= w_hi_nib;
      r_crc     <= w_crc;
      r_tx_en   <= w_tx_en;
      r_tx_data <= w_tx_data;
      r_done    <= w_done;
    end
  end

  assign bus.tx_done     = r_done;
  assign bus.txb_adr     = r_adr;
  assign bus.phy_tx_en   = r_tx_en;
  assign bus.phy_tx_data = r_tx_data;

endmodule

// File: tb/tb_minimac3_tx.sv
// Directed bench for minimac3_tx: one instance with hardware FCS, one without.
module tb_minimac3_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  minimac3_tx_if bus_a ();
  minimac3_tx_if bus_b ();

  minimac3_tx #(.HW_FCS(1'b1), .IFG_CYCLES(24)) u_fcs (
    .phy_tx_clk (clk),
    .phy_tx_rst (rst),
    .bus        (bus_a)
  );

  minimac3_tx #(.HW_FCS(1'b0), .IFG_CYCLES(24)) u_raw (
    .phy_tx_clk (clk),
    .phy_tx_rst (rst),
    .bus        (bus_b)
  );

  // Synchronous TX buffers: data one clock after the address.
  logic [7:0] mem_a [0:2047];
  logic [7:0] mem_b [0:2047];
  always @(posedge clk) begin
    bus_a.txb_dat <= mem_a[bus_a.txb_adr];
    bus_b.txb_dat <= mem_b[bus_b.txb_adr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Line monitors, sampled mid-cycle.
  logic [3:0]  cap_a [0:16383];
  logic [3:0]  cap_b [0:16383];
  int          wr_a = 0, done_n_a = 0, done_cyc_a = 0, rise_a = 0, idle_bad_a = 0, adr_jump_a = 0;
  int          wr_b = 0, done_n_b = 0, done_cyc_b = 0, rise_b = 0, idle_bad_b = 0;
  logic        en_prev_a = 1'b0, en_prev_b = 1'b0;
  logic [10:0] adr_prev_a = '0, adr_max_a = '0;

  always @(negedge clk) begin
    en_prev_a  <= bus_a.phy_tx_en;
    adr_prev_a <= bus_a.txb_adr;
    if (bus_a.phy_tx_en === 1'b1) begin
      cap_a[wr_a[13:0]] <= bus_a.phy_tx_data;
      wr_a <= wr_a + 1;
      if (en_prev_a !== 1'b1) rise_a <= cyc;
    end else if (bus_a.phy_tx_data !== 4'h0) idle_bad_a <= idle_bad_a + 1;
    if (bus_a.tx_done === 1'b1) begin
      done_n_a   <= done_n_a + 1;
      done_cyc_a <= cyc;
    end
    if (bus_a.txb_adr > adr_max_a) adr_max_a <= bus_a.txb_adr;
    if (bus_a.txb_adr != adr_prev_a && bus_a.txb_adr != adr_prev_a + 11'd1 && bus_a.txb_adr != 11'd0)
      adr_jump_a <= adr_jump_a + 1;
  end

  always @(negedge clk) begin
    en_prev_b <= bus_b.phy_tx_en;
    if (bus_b.phy_tx_en === 1'b1) begin
      cap_b[wr_b[13:0]] <= bus_b.phy_tx_data;
      wr_b <= wr_b + 1;
      if (en_prev_b !== 1'b1) rise_b <= cyc;
    end else if (bus_b.phy_tx_data !== 4'h0) idle_bad_b <= idle_bad_b + 1;
    if (bus_b.tx_done === 1'b1) begin
      done_n_b   <= done_n_b + 1;
      done_cyc_b <= cyc;
    end
  end

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] pay [0:2047];
  logic [3:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int f_done_n(input bit b);   return b ? done_n_b   : done_n_a;   endfunction
  function automatic int f_done_cyc(input bit b); return b ? done_cyc_b : done_cyc_a; endfunction
  function automatic int f_rise(input bit b);     return b ? rise_b     : rise_a;     endfunction
  function automatic int f_wr(input bit b);       return b ? wr_b       : wr_a;       endfunction
  function automatic logic [3:0] f_cap(input bit b, input int i);
    return b ? cap_b[i[13:0]] : cap_a[i[13:0]];
  endfunction

  // Byte-wise reference CRC-32; returns the complemented value sent as FCS.
  function automatic logic [31:0] crc_ref(input int n);
    logic [31:0] c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c ^= {24'h0, pay[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic advance(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic load(input bit b, input int n);
    for (int i = 0; i < n; i++) begin
      if (b) mem_b[i] = pay[i];
      else   mem_a[i] = pay[i];
    end
  endtask

  // One-cycle start pulse; returns the cycle number of that pulse.
  task automatic start(input bit b, input logic [10:0] n, output int c0);
    if (b) begin bus_b.tx_start = 1'b1; bus_b.tx_count = n; end
    else   begin bus_a.tx_start = 1'b1; bus_a.tx_count = n; end
    c0 = cyc;
    @(posedge clk); #1;
    bus_a.tx_start = 1'b0; bus_a.tx_count = 11'h5A5;
    bus_b.tx_start = 1'b0; bus_b.tx_count = 11'h5A5;
  endtask

  task automatic build_exp(input int n, input bit fcs_on, input logic [31:0] fcs);
    exp_q.delete();
    for (int i = 0; i < 15; i++) exp_q.push_back(4'h5);
    exp_q.push_back(4'hD);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(pay[i][3:0]);
      exp_q.push_back(pay[i][7:4]);
    end
    if (fcs_on) for (int k = 0; k < 8; k++) exp_q.push_back(fcs[4*k +: 4]);
  endtask

  task automatic wait_done(input bit b, input int base_n, input int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk); #1;
      if (f_done_n(b) != base_n) break;
    end
  endtask

  // Waits (bounded) for the frame to finish and checks timing and the nibble stream.
  task automatic check_frame(input bit b, input string tag, input int c0, input int base_n,
                             input int base_wr, input int exp_rel);
    int bad   = 0;
    int first = -1;
    wait_done(b, base_n, exp_rel + 50);
    check({tag, " done count"}, f_done_n(b) - base_n, 1);
    check({tag, " done cycle"}, f_done_cyc(b) - c0, exp_rel);
    check({tag, " tx_en rise cycle"}, f_rise(b) - c0, 1);
    check({tag, " tx_en cycles"}, f_wr(b) - base_wr, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (f_cap(b, base_wr + i) !== exp_q[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    check($sformatf("%s nibble errors (first at %0d)", tag, first), bad, 0);
  endtask

  initial begin
    int c0, dummy, bn, bw;
    bus_a.tx_start = 1'b0; bus_a.tx_count = '0;
    bus_b.tx_start = 1'b0; bus_b.tx_count = '0;
    for (int i = 0; i < 2048; i++) begin mem_a[i] = 8'h00; mem_b[i] = 8'h00; end

    // Reset state
    @(negedge clk); #1;
    check("rst tx_done",     bus_a.tx_done,     0);
    check("rst phy_tx_en",   bus_a.phy_tx_en,   0);
    check("rst phy_tx_data", bus_a.phy_tx_data, 0);
    check("rst txb_adr",     bus_a.txb_adr,     0);
    check("rst raw tx_en",   bus_b.phy_tx_en,   0);
    @(posedge clk); #1;
    rst = 1'b0;
    advance(2);

    // Zero-length start: done at cycle 1, nothing on the line
    bn = done_n_a; bw = wr_a;
    start(1'b0, 11'd0, c0);
    advance(30);
    check("zero done count", done_n_a - bn, 1);
    check("zero done cycle", done_cyc_a - c0, 1);
    check("zero tx_en cycles", wr_a - bw, 0);
    check("zero txb_adr max", adr_max_a, 0);

    // "123456789" with hardware FCS
    for (int i = 0; i < 9; i++) pay[i] = 8'h31 + 8'(i);
    load(1'b0, 9);
    build_exp(9, 1'b1, 32'hCBF43926);
    bn = done_n_a; bw = wr_a;
    start(1'b0, 11'd9, c0);
    check_frame(1'b0, "crc9", c0, bn, bw, 67);

    // One byte 0xA7 without hardware FCS
    pay[0] = 8'hA7;
    load(1'b1, 1);
    build_exp(1, 1'b0, 32'h0);
    bn = done_n_b; bw = wr_b;
    start(1'b1, 11'd1, c0);
    check_frame(1'b1, "nofcs1", c0, bn, bw, 43);

    // Starts during DATA and during IFG are ignored
    for (int i = 0; i < 9; i++) pay[i] = 8'h31 + 8'(i);
    build_exp(9, 1'b1, 32'hCBF43926);
    bn = done_n_a; bw = wr_a;
    start(1'b0, 11'd9, c0);
    advance(19);
    start(1'b0, 11'd3, dummy);
    advance(29);
    start(1'b0, 11'd3, dummy);
    check_frame(1'b0, "ignore", c0, bn, bw, 67);
    @(posedge clk); #1;
    bn = done_n_a; bw = wr_a;
    start(1'b0, 11'd9, c0);
    check_frame(1'b0, "back2back", c0, bn, bw, 67);

    // Reset during byte 5 of an 8-byte frame
    for (int i = 0; i < 8; i++) pay[i] = 8'h0F + 8'(i * 17);
    load(1'b0, 8);
    bn = done_n_a;
    start(1'b0, 11'd8, c0);
    advance(26);
    @(negedge clk); #1;
    check("abort tx_en before rst", bus_a.phy_tx_en,   1);
    check("abort byte5 low nibble", bus_a.phy_tx_data, pay[5][3:0]);
    rst = 1'b1;
    #1;
    check("abort tx_en in rst cycle", bus_a.phy_tx_en, 0);
    check("abort txb_adr in rst",     bus_a.txb_adr,   0);
    advance(2);
    rst = 1'b0;
    advance(60);
    check("abort no tx_done", done_n_a - bn, 0);

    pay[0] = 8'h00; pay[1] = 8'hFF; pay[2] = 8'h5A; pay[3] = 8'hC3;
    load(1'b0, 4);
    build_exp(4, 1'b1, crc_ref(4));
    bn = done_n_a; bw = wr_a;
    start(1'b0, 11'd4, c0);
    check_frame(1'b0, "after abort", c0, bn, bw, 57);

    // Maximum length frame, incrementing buffer
    for (int i = 0; i < 2047; i++) pay[i] = 8'(i);
    load(1'b0, 2047);
    build_exp(2047, 1'b1, crc_ref(2047));
    bn = done_n_a; bw = wr_a;
    start(1'b0, 11'd2047, c0);
    check_frame(1'b0, "max2047", c0, bn, bw, 1 + 16 + 4094 + 8 + 24);
    check("max txb_adr peak",  adr_max_a,     2046);
    check("max txb_adr final", bus_a.txb_adr, 2046);
    check("txb_adr steps",     adr_jump_a,    0);

    // Quiet tail: no stray done pulses, TXD idle whenever TX_EN is low
    bn = done_n_a;
    advance(40);
    check("tail no extra done", done_n_a - bn, 0);
    check("fcs idle data zero", idle_bad_a, 0);
    check("raw idle data zero", idle_bad_b, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
